// File: rtl/sync_debounce_multi.sv
// WIDTH-channel level synchronizer with per-channel debounce filter and registered rise/fall pulses.
// Define SYNC_DEBOUNCE_STICKY_EN to add clr input and rise_seen/fall_seen sticky edge flags.

module sync_debounce_multi #(
  parameter int unsigned      WIDTH     = 4,
  parameter int unsigned      STAGES    = 2,
  parameter int unsigned      DEBOUNCE  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             g_reset,
  input  logic [WIDTH-1:0] in,
`ifdef SYNC_DEBOUNCE_STICKY_EN
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] rise_seen,
  output logic [WIDTH-1:0] fall_seen,
`endif
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE - 1);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_n;
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] out_d;

  assign sync_n = sync_q[STAGES-1];

  // Pure flop chain: nothing may sit between stages or metastability settling time is lost.
  always_ff @(posedge clk) begin
    if (g_reset) begin
      for (int k = 0; k < STAGES; k++) sync_q[k] <= RESET_VAL;
    end else begin
      sync_q[0] <= in;
      for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  always_comb begin
    out_d = out;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_n[i] != out[i]) begin
        if (cnt_q[i] == CNT_LAST) out_d[i] = sync_n[i];
        else                      cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Pulses come from the same edge that updates out, so they line up with the new level.
  always_ff @(posedge clk) begin
    if (g_reset) begin
      out  <= RESET_VAL;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      out  <= out_d;
      rise <= out_d & ~out;
      fall <= ~out_d & out;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef SYNC_DEBOUNCE_STICKY_EN
  // A fresh edge beats a simultaneous clear so no event is lost.
  always_ff @(posedge clk) begin
    if (g_reset) begin
      rise_seen <= '0;
      fall_seen <= '0;
    end else begin
      rise_seen <= rise | (rise_seen & ~clr);
      fall_seen <= fall | (fall_seen & ~clr);
    end
  end
`endif

endmodule

// File: tb/tb_sync_debounce_multi.sv
// Directed bench for sync_debounce_multi (WIDTH=4, STAGES=2, DEBOUNCE=4, RESET_VAL=0).
// Cycle-accurate vector table plus hand-written mid-reset and sticky-flag sequences.

module tb_sync_debounce_multi;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         g_reset;
  logic [W-1:0] in;
  logic [W-1:0] out;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
`ifdef SYNC_DEBOUNCE_STICKY_EN
  logic [W-1:0] clr;
  logic [W-1:0] rise_seen;
  logic [W-1:0] fall_seen;
`endif

  int checks = 0;
  int errors = 0;
  logic [3*W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  sync_debounce_multi #(
    .WIDTH(4), .STAGES(2), .DEBOUNCE(4), .RESET_VAL(4'h0)
  ) dut (
    .clk(clk),
    .g_reset(g_reset),
    .in(in),
`ifdef SYNC_DEBOUNCE_STICKY_EN
    .clr(clr),
    .rise_seen(rise_seen),
    .fall_seen(fall_seen),
`endif
    .out(out),
    .rise(rise),
    .fall(fall)
  );

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic [W-1:0] v);
    @(negedge clk);
    g_reset = r;
    in      = v;
    @(posedge clk);
    #1;
  endtask

  // Drive v until the chosen pulse appears on channel ch; lat counts edges from the first one.
  task automatic wait_edge(input logic [W-1:0] v, input int ch, input bit want_rise, output int lat);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, v);
      lat++;
      if (want_rise ? rise[ch] : fall[ch]) return;
    end
    lat = 99;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic score(input string name);
    logic [3*W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s actual=empty_queue required=entry", name);
      return;
    end
    e = exp_q.pop_front();
    check(name, {out, rise, fall}, e);
    check({name, "_excl"}, rise & fall, '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         rst;
    logic [W-1:0] vin;
    int           n;
    logic [W-1:0] e_out;
    logic [W-1:0] e_rise;
    logic [W-1:0] e_fall;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  initial begin
    int lat;
    g_reset = 1'b1;
    in      = '0;
`ifdef SYNC_DEBOUNCE_STICKY_EN
    clr     = '0;
`endif

    // reset with in=F, then release: out=F on the 6th released edge
    vecs[0]  = '{1'b1, 4'hF, 3,  4'h0, 4'h0, 4'h0};
    vecs[1]  = '{1'b0, 4'hF, 5,  4'h0, 4'h0, 4'h0};
    vecs[2]  = '{1'b0, 4'hF, 1,  4'hF, 4'hF, 4'h0};
    vecs[3]  = '{1'b0, 4'hF, 2,  4'hF, 4'h0, 4'h0};
    // all channels back to 0
    vecs[4]  = '{1'b0, 4'h0, 5,  4'hF, 4'h0, 4'h0};
    vecs[5]  = '{1'b0, 4'h0, 1,  4'h0, 4'h0, 4'hF};
    vecs[6]  = '{1'b0, 4'h0, 2,  4'h0, 4'h0, 4'h0};
    // clean step on ch0, held 18 cycles
    vecs[7]  = '{1'b0, 4'h1, 5,  4'h0, 4'h0, 4'h0};
    vecs[8]  = '{1'b0, 4'h1, 1,  4'h1, 4'h1, 4'h0};
    vecs[9]  = '{1'b0, 4'h1, 12, 4'h1, 4'h0, 4'h0};
    // ch1 glitch of 3 cycles is rejected
    vecs[10] = '{1'b0, 4'h3, 3,  4'h1, 4'h0, 4'h0};
    vecs[11] = '{1'b0, 4'h1, 6,  4'h1, 4'h0, 4'h0};
    // ch1 high 4 cycles passes, then its return to 0 passes too
    vecs[12] = '{1'b0, 4'h3, 4,  4'h1, 4'h0, 4'h0};
    vecs[13] = '{1'b0, 4'h1, 1,  4'h1, 4'h0, 4'h0};
    vecs[14] = '{1'b0, 4'h1, 1,  4'h3, 4'h2, 4'h0};
    vecs[15] = '{1'b0, 4'h1, 3,  4'h3, 4'h0, 4'h0};
    vecs[16] = '{1'b0, 4'h1, 1,  4'h1, 4'h0, 4'h2};
    vecs[17] = '{1'b0, 4'h1, 2,  4'h1, 4'h0, 4'h0};
    // establish 0101, then swap all channels to 1010 at once
    vecs[18] = '{1'b0, 4'h5, 5,  4'h1, 4'h0, 4'h0};
    vecs[19] = '{1'b0, 4'h5, 1,  4'h5, 4'h4, 4'h0};
    vecs[20] = '{1'b0, 4'h5, 2,  4'h5, 4'h0, 4'h0};
    vecs[21] = '{1'b0, 4'hA, 5,  4'h5, 4'h0, 4'h0};
    vecs[22] = '{1'b0, 4'hA, 1,  4'hA, 4'hA, 4'h5};
    vecs[23] = '{1'b0, 4'hA, 2,  4'hA, 4'h0, 4'h0};

    for (int k = 0; k < NV; k++) begin
      for (int c = 0; c < vecs[k].n; c++) begin
        exp_q.push_back({vecs[k].e_out, vecs[k].e_rise, vecs[k].e_fall});
        drive(vecs[k].rst, vecs[k].vin);
        score($sformatf("vec%0d_c%0d", k, c));
      end
    end

    // ---------------- mid-operation reset with ch2 counter at 2 ----------------
    for (int k = 0; k < 8; k++) drive(1'b0, 4'h0);
    check("settle_zero", out, 4'h0);
    for (int k = 0; k < 4; k++) drive(1'b0, 4'h4);
    check("pre_reset_out", out, 4'h0);
    drive(1'b1, 4'h4);
    check("midrst_out", out, 4'h0);
    check("midrst_pulses", {rise, fall}, 8'h00);
`ifdef SYNC_DEBOUNCE_STICKY_EN
    check("midrst_seen", {rise_seen, fall_seen}, 8'h00);
`endif
    wait_edge(4'h4, 2, 1'b1, lat);
    check_range("midrst_latency", lat, 5, 7);
    check("midrst_rise", rise, 4'h4);
    check("midrst_out_after", out, 4'h4);
    drive(1'b0, 4'h4);
    check("midrst_rise_single", rise, 4'h0);

`ifdef SYNC_DEBOUNCE_STICKY_EN
    // ---------------- sticky flags on ch3 ----------------
    wait_edge(4'hC, 3, 1'b1, lat);
    check_range("st_rise_latency", lat, 5, 7);
    check("st_seen_not_yet", rise_seen[3], 1'b0);
    drive(1'b0, 4'hC);
    check("st_seen_set", rise_seen[3], 1'b1);
    drive(1'b0, 4'hC);
    check("st_seen_hold", rise_seen[3], 1'b1);
    clr = 4'h8;
    drive(1'b0, 4'hC);
    clr = 4'h0;
    check("st_seen_clr", rise_seen[3], 1'b0);
    check("st_seen_other", rise_seen[2], 1'b1);
    wait_edge(4'h4, 3, 1'b0, lat);
    check_range("st_fall_latency", lat, 5, 7);
    drive(1'b0, 4'h4);
    check("st_fall_seen", fall_seen[3], 1'b1);
    wait_edge(4'hC, 3, 1'b1, lat);
    check_range("st_rise2_latency", lat, 5, 7);
    clr = 4'h8;
    drive(1'b0, 4'hC);
    clr = 4'h0;
    check("st_set_wins", rise_seen[3], 1'b1);
    check("st_fall_clr", fall_seen[3], 1'b0);
    drive(1'b0, 4'hC);
    check("st_set_wins_hold", rise_seen[3], 1'b1);
`endif

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_debounce_multi.md
Name: sync_debounce_multi

Overview:
- Parametrised successor to the single-bit two-flop synchronizer.
- Brings WIDTH independent asynchronous inputs into the clk domain through a configurable flop chain.
- Per channel, it adds a glitch-rejecting debounce filter and single-cycle rise and fall pulses.
- Sits at the boundary between pins or foreign-domain level signals and core control logic.

Parameters:
- WIDTH, 4, number of independent channels (1..32).
- STAGES, 2, synchronizer flops per channel (2..4).
- DEBOUNCE, 4, consecutive mismatching cycles required before the filtered output changes (1..255).
- RESET_VAL, 0, WIDTH-bit reset value of sync chain, filtered output and counter state.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- g_reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  asynchronous level inputs; no timing relation to clk.
- out  output  WIDTH  synchronized, debounced level.
- rise  output  WIDTH  one-cycle pulse when out[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse when out[i] goes 1->0.

Behaviour:
- Reset, sampled on a clk edge with g_reset=1:
  - all sync flops <= RESET_VAL;
  - out <= RESET_VAL;
  - all counters <= 0;
  - rise = fall = 0.
- Reset asserted mid-operation overrides everything on that edge, including any pending transition. No rise or fall pulse is generated by reset itself.
- Sync chain, per channel:
  - s1 <= in[i], s2 <= s1, ..., sN <= s(N-1), with N = STAGES.
  - Only sN is used downstream.
  - No logic between chain flops.
- Debounce counter, per channel, width ceil(log2(DEBOUNCE+1)) bits:
  - Match: if sN == out[i], counter <= 0.
  - Mismatch, counter < DEBOUNCE-1: counter <= counter+1.
  - Mismatch, counter == DEBOUNCE-1: out[i] <= sN, counter <= 0.
  - The counter never exceeds DEBOUNCE-1 and never wraps.
- Latency: a clean step on in[i], held stable, appears on out[i] exactly STAGES+DEBOUNCE clk edges after the first edge that samples the new level.
  - Metastability resolution may add one extra cycle; the bench must tolerate ±1.
- Glitch rejection: any excursion of sN lasting fewer than DEBOUNCE consecutive cycles leaves out[i] unchanged and clears its counter.
- Edge pulses:
  - rise[i] and fall[i] are registered.
  - They are asserted in the same cycle out[i] first shows its new value, for exactly one cycle.
  - rise[i] and fall[i] are never high together.
  - Minimum spacing between pulses on one channel is DEBOUNCE cycles.
- Channels are fully independent. Simultaneous transitions on several channels are handled in parallel with identical latency.

Optional Feature:
- Macro: SYNC_DEBOUNCE_STICKY_EN.
- Defined: adds the following ports.
  - Input clr (WIDTH).
  - Outputs rise_seen and fall_seen (WIDTH).
- rise_seen[i] sets on the cycle after rise[i] and holds until clr[i]=1 is sampled. fall_seen behaves the same way with fall[i].
- Set and clear on the same edge: set wins, so the bit stays 1.
- Reset clears both to 0.
- Undefined: the ports and registers are absent. Core behaviour is identical.

Test Plan:
- Reset: hold g_reset=1 for 3 cycles with in=4'hF (RESET_VAL=0) -> out=0, rise=fall=0 throughout. After release, out=4'hF at edge 6 (±1), with a single rise=4'hF pulse.
- Clean step: in[0] 0->1 held 20 cycles -> out[0] rises exactly 6 edges after sampling, rise[0]=1 for one cycle, other channels unchanged.
- Glitch: in[1] high for 3 cycles then low (DEBOUNCE=4) -> out[1] stays 0, no rise/fall. High for 4+ cycles -> out[1] rises.
- Multi-channel: in=4'b0101 -> 4'b1010 in one cycle -> out switches all bits on the same edge, with rise=4'b1010 and fall=4'b0101 in the same cycle.
- Mid-operation reset: assert g_reset while the channel-2 counter is at 2 -> no out change, counter restarts from 0 after release, and full latency is measured again.
- With SYNC_DEBOUNCE_STICKY_EN: a rise on ch3 sets rise_seen[3]. A clr[3] pulse clears it. clr[3] coincident with a new set leaves rise_seen[3]=1.
